uns_acc_ctrl: RTL and testbench
===============================

# uns_acc_ctrl

Command sequencer for the unsigned accumulator datapath. It accepts accumulate jobs over a valid/ready interface: each job carries a select code, two operands and a cycle count. For each job it clears the accumulator, drives it for the requested number of cycles, then captures the result and the overflow. A one-deep pending buffer lets the next job be queued while the current one runs, so consecutive jobs run back-to-back.

## Interface
Parameters:
- DW, 3, operand width (accumulator i_data1/i_data2)
- AW, 6, accumulator result width
- LW, 4, job length field width (0..2^LW-1 cycles)

Ports:
- clk  in  1  single clock, all logic on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_cmd_valid  in  1  job request valid
- o_cmd_ready  out  1  job accepted on edge where valid & ready
- i_cmd_sel  in  2  accumulator select code for the job
- i_cmd_data1, i_cmd_data2  in  DW  operands for the job
- i_cmd_len  in  LW  number of accumulate cycles
- i_abort  in  1  cancel active and pending jobs
- o_acc_rst_n  out  1  drives accumulator i_rst_n (0 = hold cleared)
- o_acc_sel  out  2  drives accumulator i_sel
- o_acc_data1, o_acc_data2  out  DW  drive accumulator operands
- i_acc_data  in  AW  accumulator o_data
- i_acc_carry  in  1  accumulator o_carry
- o_done  out  1  one-cycle pulse: o_result/o_ovf updated
- o_result  out  AW  captured accumulator value of last completed job
- o_ovf  out  1  sticky OR of i_acc_carry over last completed job
- o_busy  out  1  state != IDLE

## Operation
- Registers: active job (sel, data1, data2, len), pending job plus pending_valid, cycle counter (LW bits), carry sticky bit.
- o_cmd_ready = !pending_valid & !i_abort.
- States: IDLE, RUN, CAPTURE.
  - IDLE: o_acc_rst_n=0. On accept, load job into active. Go to RUN if len>0, else CAPTURE.
  - RUN: o_acc_rst_n=1. o_acc_sel/data driven from active. Counter counts up from 0; after len cycles in RUN, go to CAPTURE.
  - CAPTURE: o_acc_rst_n=0. At the exit edge: o_result<=i_acc_data; o_ovf<=sticky|i_acc_carry; o_done<=1 next cycle; sticky clears.
    - Next job: if pending_valid, pending moves to active and pending_valid clears. Else, a job accepted on this edge loads directly into active. Else go to IDLE.
    - The next job enters RUN or CAPTURE by its len.
- Accept while busy (ready=1) loads the pending buffer.
- Sticky: ORs i_acc_carry on every RUN edge.
- len=0: no RUN cycles. The accumulator stays cleared, so o_result=0 and o_ovf=0 (i_acc_carry is 0 while cleared).
- Abort (RUN or CAPTURE): on the edge, go to IDLE. Clear pending_valid and sticky. No o_done. o_result/o_ovf keep their previous values. Abort in IDLE is ignored.
- o_acc_sel/data hold last active values in IDLE.

## Timing
- Reset values: state IDLE, o_acc_rst_n=0, o_cmd_ready=1, o_done=0, o_result=0, o_ovf=0, o_busy=0, o_acc_sel=0, o_acc_data1/2=0, pending_valid=0, counter=0, sticky=0.
- Reset mid-job drops both jobs with no o_done.
- Single job accepted at edge T:
  - RUN occupies cycles T+1..T+len.
  - CAPTURE occupies cycle T+len+1.
  - o_done is high in cycle T+len+2 only.
- Back-to-back throughput: len+1 cycles per job. CAPTURE holds the accumulator cleared for one cycle between jobs.
- o_result and o_ovf change only on the edge that raises o_done, and stay stable until the next job completes.
- i_abort has priority over capture and accept on the same edge.

## Test plan
Bench accumulator model: o_data <= o_data + i_data1 (mod 64) while i_rst_n=1; o_carry=1 on the wrap cycle.
- Reset 10 cycles, then job sel=00, d1=3, d2=2, len=5 -> o_acc_rst_n high exactly 5 cycles; o_done 7 cycles after accept; o_result=15, o_ovf=0.
- Job d1=7, len=10 -> o_result=6 (70 mod 64), o_ovf=1. Next job d1=1, len=2 -> o_result=2, o_ovf=0 (sticky cleared).
- Jobs A (d1=2, len=3) and B (d1=5, len=4), both issued on consecutive cycles -> B accepted during A's RUN, o_cmd_ready low until A's CAPTURE exit. Results 6 then 20; done pulses 5 cycles apart.
- Job len=0 -> RUN skipped; o_done 2 cycles after accept; o_result=0, o_ovf=0.
- Job len=10 plus a pending job, i_abort at RUN cycle 4 -> IDLE next cycle; no o_done; o_result unchanged; pending dropped; o_cmd_ready=1.
- i_rst_n low mid-RUN -> all outputs at reset values next cycle; no o_done.

Source files
------------

// File: rtl/uns_acc_ctrl_if.sv
// Job command channel for the accumulator sequencer: valid/ready handshake plus job fields.
// The master drives requests and the slave (the sequencer) returns ready.
interface uns_acc_ctrl_if #(
  parameter int DW = 3,
  parameter int LW = 4
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_sel;
  logic [DW-1:0] cmd_data1;
  logic [DW-1:0] cmd_data2;
  logic [LW-1:0] cmd_len;

  modport master (
    output cmd_valid, cmd_sel, cmd_data1, cmd_data2, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_data1, cmd_data2, cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/uns_acc_ctrl.sv
// Command sequencer for the unsigned accumulator: runs each job for len cycles, captures
// result and overflow, and keeps a one-deep pending job so jobs run back-to-back.
module uns_acc_ctrl #(
  parameter int DW = 3,
  parameter int AW = 6,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          i_rst_n,
  uns_acc_ctrl_if.slave cmd,
  input  logic          i_abort,
  output logic          o_acc_rst_n,
  output logic [1:0]    o_acc_sel,
  output logic [DW-1:0] o_acc_data1,
  output logic [DW-1:0] o_acc_data2,
  input  logic [AW-1:0] i_acc_data,
  input  logic          i_acc_carry,
  output logic          o_done,
  output logic [AW-1:0] o_result,
  output logic          o_ovf,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic [LW-1:0] LEN_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] CNT_ONE  = {{(LW-1){1'b0}}, 1'b1};

  state_t        state_r, state_nxt_s;

  logic [1:0]    act_sel_r;
  logic [DW-1:0] act_data1_r, act_data2_r;
  logic [LW-1:0] act_len_r;
  logic [1:0]    pend_sel_r;
  logic [DW-1:0] pend_data1_r, pend_data2_r;
  logic [LW-1:0] pend_len_r;
  logic          pend_valid_r;
  logic [LW-1:0] cnt_r;
  logic          sticky_r;
  logic          acc_rst_n_r, busy_r, done_r, ovf_r;
  logic [AW-1:0] result_r;

  logic ready_s, accept_s;
  logic load_act_cmd_s, load_act_pend_s, load_pend_s;
  logic run_s, capture_s, abort_s;

  // Abort blocks acceptance so a job cannot slip in on the cancelling edge.
  assign ready_s  = ~pend_valid_r & ~i_abort;
  assign accept_s = cmd.cmd_valid & ready_s;

  // State register.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-edge job control strobes.
  always_comb begin
    state_nxt_s     = state_r;
    load_act_cmd_s  = 1'b0;
    load_act_pend_s = 1'b0;
    load_pend_s     = 1'b0;
    run_s           = 1'b0;
    capture_s       = 1'b0;
    abort_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          load_act_cmd_s = 1'b1;
          state_nxt_s    = (cmd.cmd_len != LEN_ZERO) ? ST_RUN : ST_CAPTURE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          run_s       = 1'b1;
          load_pend_s = accept_s;
          if ((cnt_r + CNT_ONE) == act_len_r) begin
            state_nxt_s = ST_CAPTURE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
      end
      ST_CAPTURE: begin
        if (i_abort) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          capture_s = 1'b1;
          // A queued job wins; ready is low whenever one is queued, so no accept competes.
          if (pend_valid_r) begin
            load_act_pend_s = 1'b1;
            state_nxt_s     = (pend_len_r != LEN_ZERO) ? ST_RUN : ST_CAPTURE;
          end else if (accept_s) begin
            load_act_cmd_s = 1'b1;
            state_nxt_s    = (cmd.cmd_len != LEN_ZERO) ? ST_RUN : ST_CAPTURE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Active and pending job buffers.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      act_sel_r    <= 2'd0;
      act_data1_r  <= {DW{1'b0}};
      act_data2_r  <= {DW{1'b0}};
      act_len_r    <= {LW{1'b0}};
      pend_sel_r   <= 2'd0;
      pend_data1_r <= {DW{1'b0}};
      pend_data2_r <= {DW{1'b0}};
      pend_len_r   <= {LW{1'b0}};
      pend_valid_r <= 1'b0;
    end else begin
      if (load_act_cmd_s) begin
        act_sel_r   <= cmd.cmd_sel;
        act_data1_r <= cmd.cmd_data1;
        act_data2_r <= cmd.cmd_data2;
        act_len_r   <= cmd.cmd_len;
      end else if (load_act_pend_s) begin
        act_sel_r   <= pend_sel_r;
        act_data1_r <= pend_data1_r;
        act_data2_r <= pend_data2_r;
        act_len_r   <= pend_len_r;
      end
      if (load_pend_s) begin
        pend_sel_r   <= cmd.cmd_sel;
        pend_data1_r <= cmd.cmd_data1;
        pend_data2_r <= cmd.cmd_data2;
        pend_len_r   <= cmd.cmd_len;
        pend_valid_r <= 1'b1;
      end else if (load_act_pend_s || abort_s) begin
        pend_valid_r <= 1'b0;
      end
    end
  end

  // Run counter and carry sticky; both return to zero outside RUN.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      cnt_r    <= {LW{1'b0}};
      sticky_r <= 1'b0;
    end else begin
      if (run_s && (state_nxt_s == ST_RUN)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= {LW{1'b0}};
      end
      if (run_s) begin
        sticky_r <= sticky_r | i_acc_carry;
      end else begin
        sticky_r <= 1'b0;
      end
    end
  end

  // Registered status and the captured result of the last completed job.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      acc_rst_n_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= {AW{1'b0}};
      ovf_r       <= 1'b0;
    end else begin
      acc_rst_n_r <= (state_nxt_s == ST_RUN);
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= capture_s;
      if (capture_s) begin
        result_r <= i_acc_data;
        ovf_r    <= sticky_r | i_acc_carry;
      end
    end
  end

  assign cmd.cmd_ready = ready_s;
  assign o_acc_rst_n   = acc_rst_n_r;
  assign o_acc_sel     = act_sel_r;
  assign o_acc_data1   = act_data1_r;
  assign o_acc_data2   = act_data2_r;
  assign o_done        = done_r;
  assign o_result      = result_r;
  assign o_ovf         = ovf_r;
  assign o_busy        = busy_r;

endmodule

// File: tb/tb_uns_acc_ctrl.sv
// Self-checking bench for uns_acc_ctrl: directed test-plan jobs then random traffic, checked
// against a job-schedule reference model and a behavioural accumulator.
module tb_uns_acc_ctrl;
  localparam int DW = 3;
  localparam int AW = 6;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          abort;
  logic          acc_rst_n;
  logic [1:0]    acc_sel;
  logic [DW-1:0] acc_d1, acc_d2;
  logic [AW-1:0] acc_data;
  logic          acc_carry;
  logic          done, ovf, busy;
  logic [AW-1:0] result;
  logic [AW:0]   acc_sum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: job schedule computed from load edge and length
  bit       m_valid = 1'b0;
  bit       m_busy, m_pend, m_done, m_ovf;
  int       m_load, m_res;
  bit [1:0] a_sel, p_sel;
  int       a_d1, a_d2, a_len, p_d1, p_d2, p_len;

  int hi_cnt, acc_cyc, done_last, done_prev;

  always #5 clk = ~clk;

  uns_acc_ctrl_if #(.DW(DW), .LW(LW)) cmd_if ();

  uns_acc_ctrl #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk         (clk),
    .i_rst_n     (rst_n),
    .cmd         (cmd_if),
    .i_abort     (abort),
    .o_acc_rst_n (acc_rst_n),
    .o_acc_sel   (acc_sel),
    .o_acc_data1 (acc_d1),
    .o_acc_data2 (acc_d2),
    .i_acc_data  (acc_data),
    .i_acc_carry (acc_carry),
    .o_done      (done),
    .o_result    (result),
    .o_ovf       (ovf),
    .o_busy      (busy)
  );

  // behavioural accumulator: adds data1 while enabled, carry flags the wrap
  assign acc_sum = {1'b0, acc_data} + {{(AW+1-DW){1'b0}}, acc_d1};
  always @(posedge clk) begin
    if (!acc_rst_n) begin
      acc_data  <= '0;
      acc_carry <= 1'b0;
    end else begin
      acc_data  <= acc_sum[AW-1:0];
      acc_carry <= acc_sum[AW];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic load_job(input int e, input bit [1:0] s, input int d1, input int d2, input int len);
    m_busy = 1'b1;
    m_load = e;
    a_sel  = s;
    a_d1   = d1;
    a_d2   = d2;
    a_len  = len;
  endtask

  task automatic step(input bit v, input bit [1:0] s, input bit [DW-1:0] d1,
                      input bit [DW-1:0] d2, input bit [LW-1:0] len,
                      input bit ab, input bit rn, output bit accepted);
    bit exp_ready;
    int prod;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_sel   = s;
    cmd_if.cmd_data1 = d1;
    cmd_if.cmd_data2 = d2;
    cmd_if.cmd_len   = len;
    abort            = ab;
    rst_n            = rn;
    #1;
    exp_ready = !m_pend && !ab;
    if (m_valid) begin
      check_eq("cmd_ready", cmd_if.cmd_ready, exp_ready);
      check_eq("done", done, m_done);
      check_eq("result", result, m_res);
      check_eq("ovf", ovf, m_ovf);
      check_eq("busy", busy, m_busy);
      check_eq("acc_rst_n", acc_rst_n, m_busy && (cyc < m_load + a_len));
      check_eq("acc_sel", acc_sel, a_sel);
      check_eq("acc_data1", acc_d1, a_d1);
      check_eq("acc_data2", acc_d2, a_d2);
    end
    if (acc_rst_n === 1'b1) hi_cnt++;
    if (done === 1'b1) begin
      done_prev = done_last;
      done_last = cyc;
    end
    accepted = v && exp_ready && rn && m_valid;
    m_done   = 1'b0;
    if (!rn) begin
      m_valid = 1'b1;
      m_busy = 1'b0; m_pend = 1'b0; m_res = 0; m_ovf = 1'b0;
      a_sel = 2'd0; a_d1 = 0; a_d2 = 0; a_len = 0;
    end else if (ab && m_busy) begin
      m_busy = 1'b0;
      m_pend = 1'b0;
    end else if (m_busy && cyc == m_load + a_len) begin
      prod   = a_len * a_d1;
      m_done = 1'b1;
      m_res  = prod % 64;
      m_ovf  = (prod >= 64);
      if (m_pend) begin
        load_job(cyc + 1, p_sel, p_d1, p_d2, p_len);
        m_pend = 1'b0;
      end else if (accepted) begin
        load_job(cyc + 1, s, d1, d2, len);
      end else begin
        m_busy = 1'b0;
      end
    end else if (m_busy) begin
      if (accepted) begin
        m_pend = 1'b1;
        p_sel = s; p_d1 = d1; p_d2 = d2; p_len = len;
      end
    end else if (accepted) begin
      load_job(cyc + 1, s, d1, d2, len);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1, a);
  endtask

  task automatic job(input bit [1:0] s, input bit [DW-1:0] d1, input bit [DW-1:0] d2,
                     input bit [LW-1:0] len);
    bit a;
    int tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 50) begin
      acc_cyc = cyc;
      step(1'b1, s, d1, d2, len, 1'b0, 1'b1, a);
      tries++;
    end
    check_eq("accept", a, 1'b1);
  endtask

  initial begin
    bit a;
    m_busy = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_res = 0; m_load = 0;
    a_sel = 2'd0; a_d1 = 0; a_d2 = 0; a_len = 0;
    done_last = 0; done_prev = 0; hi_cnt = 0; acc_cyc = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) step(1'b0, 2'd0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0, a);
    idle(2);

    hi_cnt = 0;
    job(2'd0, 3'd3, 3'd2, 4'd5);
    idle(8);
    check_eq("t1_run_cycles", hi_cnt, 5);
    check_eq("t1_done_latency", done_last - acc_cyc, 7);
    check_eq("t1_result", result, 15);
    check_eq("t1_ovf", ovf, 0);

    job(2'd1, 3'd7, 3'd0, 4'd10);
    idle(13);
    check_eq("t2_result", result, 6);
    check_eq("t2_ovf", ovf, 1);
    job(2'd2, 3'd1, 3'd0, 4'd2);
    idle(5);
    check_eq("t3_result", result, 2);
    check_eq("t3_ovf", ovf, 0);

    job(2'd0, 3'd2, 3'd0, 4'd3);
    job(2'd0, 3'd5, 3'd0, 4'd4);
    idle(12);
    check_eq("b2b_spacing", done_last - done_prev, 5);
    check_eq("b2b_result", result, 20);

    job(2'd3, 3'd4, 3'd4, 4'd0);
    idle(3);
    check_eq("len0_latency", done_last - acc_cyc, 2);
    check_eq("len0_result", result, 0);

    job(2'd1, 3'd6, 3'd1, 4'd10);
    job(2'd2, 3'd3, 3'd3, 4'd3);
    idle(2);
    step(1'b0, 2'd0, 3'd0, 3'd0, 4'd0, 1'b1, 1'b1, a);
    idle(15);
    check_eq("abort_result", result, 0);

    job(2'd0, 3'd5, 3'd0, 4'd8);
    idle(3);
    step(1'b0, 2'd0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0, a);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(1, 0) == 1, 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)),
           3'($urandom_range(7, 0)), 4'($urandom_range(15, 0)),
           $urandom_range(39, 0) == 0, $urandom_range(199, 0) != 0, a);
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
